// File: rtl/game_flow_controller.sv
// Game screen sequencer: start screen, play, hit blink, game over; owns the lives count.
// Every output is a register loaded from the next-state logic, so input events show one cycle later.
module game_flow_controller #(
  parameter int MAX_LIVES    = 3,
  parameter int HIT_FRAMES   = 60,
  parameter int BLINK_FRAMES = 8,
  parameter int OVER_FRAMES  = 180,
  parameter int MAX_LEVEL    = 7
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 startKey,
  input  logic                 playerHit,
  input  logic                 allAliensDead,
  output logic [MAX_LIVES-1:0] lives,
  output logic                 startScreenEn,
  output logic                 gameOverEn,
  output logic                 gameRunning,
  output logic                 playerVisible,
  output logic                 newGame,
  output logic                 levelUp,
  output logic [2:0]           level
);

  localparam int LCW = $clog2(MAX_LIVES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_HIT, S_OVER} state_t;

  state_t         r_state, w_stateNxt;
  logic [LCW-1:0] r_livesCnt, w_livesCntNxt;
  logic [7:0]     r_frameCnt, w_frameCntNxt;
  logic [7:0]     r_blinkCnt, w_blinkCntNxt;
  logic           r_keyPrev, r_keyBlock;
  logic           w_keyRise;
  logic           w_visNxt, w_newGameNxt, w_levelUpNxt;
  logic [2:0]     w_levelNxt;

  function automatic logic [MAX_LIVES-1:0] f_livesMask(input logic [LCW-1:0] cnt);
    logic [MAX_LIVES:0] t;
    t = ({{MAX_LIVES{1'b0}}, 1'b1} << cnt) - {{MAX_LIVES{1'b0}}, 1'b1};
    return t[MAX_LIVES-1:0];
  endfunction

  function automatic logic [2:0] f_levelInc(input logic [2:0] lv);
    return (lv >= 3'(MAX_LEVEL)) ? lv : lv + 3'd1;
  endfunction

  // r_keyBlock masks a key that was already down when reset was applied
  assign w_keyRise = startKey & ~r_keyPrev & ~r_keyBlock;

  always_comb begin
    w_stateNxt    = r_state;
    w_livesCntNxt = r_livesCnt;
    w_frameCntNxt = r_frameCnt;
    w_blinkCntNxt = r_blinkCnt;
    w_visNxt      = playerVisible;
    w_newGameNxt  = 1'b0;
    w_levelUpNxt  = 1'b0;
    w_levelNxt    = level;
    case (r_state)
      S_IDLE: begin
        if (w_keyRise) begin
          w_stateNxt    = S_PLAYING;
          w_newGameNxt  = 1'b1;
          w_livesCntNxt = LCW'(MAX_LIVES);
          w_levelNxt    = 3'd0;
          w_visNxt      = 1'b1;
          w_frameCntNxt = 8'd0;
          w_blinkCntNxt = 8'd0;
        end
      end
      S_PLAYING: begin
        w_visNxt = 1'b1;
        if (playerHit) begin
          w_frameCntNxt = 8'd0;
          w_blinkCntNxt = 8'd0;
          w_visNxt      = 1'b0;
          if (r_livesCnt > LCW'(1)) begin
            w_livesCntNxt = r_livesCnt - LCW'(1);
            w_stateNxt    = S_HIT;
          end else begin
            w_livesCntNxt = '0;
            w_stateNxt    = S_OVER;
          end
        end else if (allAliensDead) begin
          w_levelUpNxt = 1'b1;
          w_levelNxt   = f_levelInc(level);
        end
      end
      S_HIT: begin
        if (allAliensDead) begin
          w_levelUpNxt = 1'b1;
          w_levelNxt   = f_levelInc(level);
        end
        if (startOfFrame) begin
          if (r_frameCnt == 8'(HIT_FRAMES - 1)) begin
            w_stateNxt    = S_PLAYING;
            w_visNxt      = 1'b1;
            w_frameCntNxt = 8'd0;
            w_blinkCntNxt = 8'd0;
          end else begin
            w_frameCntNxt = r_frameCnt + 8'd1;
            if (r_blinkCnt == 8'(BLINK_FRAMES - 1)) begin
              w_visNxt      = ~playerVisible;
              w_blinkCntNxt = 8'd0;
            end else begin
              w_blinkCntNxt = r_blinkCnt + 8'd1;
            end
          end
        end
      end
      S_OVER: begin
        w_visNxt = 1'b0;
        if (startOfFrame) begin
          if (r_frameCnt == 8'(OVER_FRAMES - 1)) begin
            w_stateNxt    = S_IDLE;
            w_livesCntNxt = LCW'(MAX_LIVES);
            w_frameCntNxt = 8'd0;
          end else begin
            w_frameCntNxt = r_frameCnt + 8'd1;
          end
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state       <= S_IDLE;
      r_livesCnt    <= LCW'(MAX_LIVES);
      r_frameCnt    <= 8'd0;
      r_blinkCnt    <= 8'd0;
      r_keyPrev     <= 1'b0;
      r_keyBlock    <= startKey;
      lives         <= '1;
      startScreenEn <= 1'b1;
      gameOverEn    <= 1'b0;
      gameRunning   <= 1'b0;
      playerVisible <= 1'b0;
      newGame       <= 1'b0;
      levelUp       <= 1'b0;
      level         <= 3'd0;
    end else begin
      r_state       <= w_stateNxt;
      r_livesCnt    <= w_livesCntNxt;
      r_frameCnt    <= w_frameCntNxt;
      r_blinkCnt    <= w_blinkCntNxt;
      r_keyPrev     <= startKey;
      r_keyBlock    <= r_keyBlock & startKey;
      lives         <= f_livesMask(w_livesCntNxt);
      startScreenEn <= (w_stateNxt == S_IDLE);
      gameOverEn    <= (w_stateNxt == S_OVER);
      gameRunning   <= (w_stateNxt == S_PLAYING) || (w_stateNxt == S_HIT);
      playerVisible <= w_visNxt;
      newGame       <= w_newGameNxt;
      levelUp       <= w_levelUpNxt;
      level         <= w_levelNxt;
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed vector table, corner-case sequences, random run vs model.
module tb_game_flow_controller;

  localparam int MAXL  = 3;
  localparam int HITF  = 60;
  localparam int BLNK  = 8;
  localparam int OVERF = 180;
  localparam int MAXLV = 7;
  localparam logic [12:0] RST_OUT = {3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

  logic clk = 1'b0;
  logic rst = 1'b0, sof = 1'b0, key = 1'b0, hit = 1'b0, clr = 1'b0;
  logic [MAXL-1:0] lives;
  logic sse, goe, run, vis, ng, lu;
  logic [2:0] lvl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_flow_controller #(
    .MAX_LIVES(MAXL), .HIT_FRAMES(HITF), .BLINK_FRAMES(BLNK),
    .OVER_FRAMES(OVERF), .MAX_LEVEL(MAXLV)
  ) dut (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .startKey(key),
    .playerHit(hit), .allAliensDead(clr), .lives(lives),
    .startScreenEn(sse), .gameOverEn(goe), .gameRunning(run),
    .playerVisible(vis), .newGame(ng), .levelUp(lu), .level(lvl)
  );

  // Behavioural model: game described by counts of lives, frames since hit, frames since game over.
  bit m_in, m_over, m_hit, m_prev, m_block, m_ng, m_lu;
  int m_lives, m_level, m_hf, m_of;

  task automatic model_step(input bit r, input bit s, input bit k, input bit h, input bit c);
    bit rise;
    m_ng = 0;
    m_lu = 0;
    if (r) begin
      m_in = 0; m_over = 0; m_hit = 0; m_lives = MAXL; m_level = 0;
      m_prev = 0; m_block = k; m_hf = 0; m_of = 0;
      return;
    end
    rise = k && !m_prev && !m_block;
    m_prev = k;
    if (!k) m_block = 0;
    if (m_over) begin
      if (s) begin
        m_of++;
        if (m_of == OVERF) begin m_over = 0; m_lives = MAXL; end
      end
    end else if (!m_in) begin
      if (rise) begin m_in = 1; m_ng = 1; m_lives = MAXL; m_level = 0; m_hit = 0; end
    end else if (m_hit) begin
      if (c) begin m_lu = 1; m_level = (m_level + 1 > MAXLV) ? MAXLV : m_level + 1; end
      if (s) begin
        m_hf++;
        if (m_hf == HITF) m_hit = 0;
      end
    end else if (h) begin
      m_lives--;
      if (m_lives == 0) begin m_in = 0; m_over = 1; m_of = 0; end
      else begin m_hit = 1; m_hf = 0; end
    end else if (c) begin
      m_lu = 1;
      m_level = (m_level + 1 > MAXLV) ? MAXLV : m_level + 1;
    end
  endtask

  function automatic logic [12:0] model_out();
    int mask;
    bit v;
    mask = m_over ? 0 : ((1 << m_lives) - 1);
    v = m_in && (!m_hit || ((m_hf / BLNK) % 2) == 1);
    return {3'(mask), !m_in && !m_over, m_over, m_in, v, m_ng, m_lu, 3'(m_level)};
  endfunction

  function automatic logic [12:0] dut_out();
    return {lives, sse, goe, run, vis, ng, lu, lvl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit k, input bit h, input bit c);
    rst = r; sof = s; key = k; hit = h; clr = c;
    @(posedge clk);
    model_step(r, s, k, h, c);
    #1;
    chk("outputs_vs_model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
    end
  endtask

  task automatic start_game();
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r, s, k, h, c;
    logic [12:0] want;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit s, input bit k, input bit h, input bit c,
                              input logic [2:0] lv, input bit e_sse, input bit e_goe,
                              input bit e_run, input bit e_vis, input bit e_ng,
                              input bit e_lu, input logic [2:0] e_lvl);
    vec_t v;
    v.r = r; v.s = s; v.k = k; v.h = h; v.c = c;
    v.want = {lv, e_sse, e_goe, e_run, e_vis, e_ng, e_lu, e_lvl};
    return v;
  endfunction

  vec_t vt[14];

  initial begin
    int lu_cnt;
    bit want_vis;
    //        r s k h c  lives  sse goe run vis ng lu lvl
    vt[0]  = mk(1,0,0,0,0, 3'b111, 1, 0, 0, 0, 0, 0, 3'd0);
    vt[1]  = mk(0,0,1,0,0, 3'b111, 0, 0, 1, 1, 1, 0, 3'd0);
    vt[2]  = mk(0,0,1,0,0, 3'b111, 0, 0, 1, 1, 0, 0, 3'd0);
    vt[3]  = mk(0,0,0,0,1, 3'b111, 0, 0, 1, 1, 0, 1, 3'd1);
    vt[4]  = mk(0,0,0,0,0, 3'b111, 0, 0, 1, 1, 0, 0, 3'd1);
    vt[5]  = mk(0,0,0,1,1, 3'b011, 0, 0, 1, 0, 0, 0, 3'd1);
    vt[6]  = mk(0,0,0,1,0, 3'b011, 0, 0, 1, 0, 0, 0, 3'd1);
    vt[7]  = mk(0,0,0,0,1, 3'b011, 0, 0, 1, 0, 0, 1, 3'd2);
    vt[8]  = mk(0,1,0,0,0, 3'b011, 0, 0, 1, 0, 0, 0, 3'd2);
    vt[9]  = mk(1,0,1,0,0, 3'b111, 1, 0, 0, 0, 0, 0, 3'd0);
    vt[10] = mk(0,0,1,0,0, 3'b111, 1, 0, 0, 0, 0, 0, 3'd0);
    vt[11] = mk(0,0,0,0,0, 3'b111, 1, 0, 0, 0, 0, 0, 3'd0);
    vt[12] = mk(0,0,1,0,0, 3'b111, 0, 0, 1, 1, 1, 0, 3'd0);
    vt[13] = mk(0,0,1,1,0, 3'b011, 0, 0, 1, 0, 0, 0, 3'd0);

    #2;
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].r; sof = vt[i].s; key = vt[i].k; hit = vt[i].h; clr = vt[i].c;
      @(posedge clk);
      model_step(vt[i].r, vt[i].s, vt[i].k, vt[i].h, vt[i].c);
      #1;
      chk($sformatf("vector_%0d", i), 32'(dut_out()), 32'(vt[i].want));
    end

    // Blink pattern through a full invulnerability window, with an ignored hit at frame 20
    drive(1, 0, 0, 0, 0);
    start_game();
    drive(0, 0, 0, 1, 0);
    chk("hit1_lives", 32'(lives), 32'(3'b011));
    chk("hit1_vis", 32'(vis), 32'(0));
    for (int k = 1; k <= HITF; k++) begin
      drive(0, 1, 0, 0, 0);
      want_vis = (k == HITF) ? 1'b1 : (((k / BLNK) % 2) == 1);
      chk($sformatf("blink_vis_f%0d", k), 32'(vis), 32'(want_vis));
      if (k == 20) begin
        drive(0, 0, 0, 1, 0);
        chk("invuln_lives", 32'(lives), 32'(3'b011));
      end else begin
        drive(0, 0, 0, 0, 0);
      end
    end
    chk("hit_end_running", 32'(run), 32'(1));
    chk("hit_end_vis", 32'(vis), 32'(1));

    // Three hits to game over, then the hold period back to the start screen
    drive(1, 0, 0, 0, 0);
    start_game();
    drive(0, 0, 0, 1, 0);
    frames(HITF);
    drive(0, 0, 0, 1, 0);
    chk("hit2_lives", 32'(lives), 32'(3'b001));
    frames(HITF);
    drive(0, 0, 0, 1, 0);
    chk("hit3_lives", 32'(lives), 32'(3'b000));
    chk("over_en", 32'(goe), 32'(1));
    chk("over_running", 32'(run), 32'(0));
    frames(OVERF - 1);
    chk("over_hold", 32'({goe, sse}), 32'(2'b10));
    frames(1);
    chk("over_exit", 32'({lives, sse, goe}), 32'({3'b111, 1'b1, 1'b0}));

    // Level saturation
    drive(1, 0, 0, 0, 0);
    start_game();
    lu_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 0, 1);
      if (lu === 1'b1) lu_cnt++;
      drive(0, 0, 0, 0, 0);
    end
    chk("levelup_pulses", 32'(lu_cnt), 32'(9));
    chk("level_saturated", 32'(lvl), 32'(MAXLV));

    // Reset mid-blink and mid-game-over
    drive(1, 0, 0, 0, 0);
    start_game();
    drive(0, 0, 0, 1, 0);
    frames(30);
    drive(1, 0, 0, 0, 0);
    chk("reset_in_hit", 32'(dut_out()), 32'(RST_OUT));
    start_game();
    drive(0, 0, 0, 1, 0);
    frames(HITF);
    drive(0, 0, 0, 1, 0);
    frames(HITF);
    drive(0, 0, 0, 1, 0);
    frames(10);
    drive(1, 0, 0, 0, 0);
    chk("reset_in_over", 32'(dut_out()), 32'(RST_OUT));

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r, s, k, h, c;
      r = ($urandom % 400) == 0;
      s = ($urandom % 3) == 0;
      k = (($urandom % 6) == 0) ? !key : key;
      h = ($urandom % 25) == 0;
      c = ($urandom % 15) == 0;
      drive(r, s, k, h, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Sequences the game screens and owns the player-lives resource.
- Runs the start screen, play, hit-invulnerability blink, level-clear and game-over phases.
- Drives the lives mask consumed by the lives/start-screen bitmap drawer, plus the screen enables and player-visibility gate used by the object drawers.
- Sits between the input/collision logic and the VGA bitmap layer; all timing is in VGA frames.

Parameters:
- MAX_LIVES, 3, lives at new game; width of lives mask (1..3).
- HIT_FRAMES, 60, frames of invulnerability after a hit.
- BLINK_FRAMES, 8, frames per player-visibility half-period during HIT.
- OVER_FRAMES, 180, frames the game-over screen is held before returning to start.
- MAX_LEVEL, 7, saturating level limit (level is 3 bits).

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous, active-high reset (asserted = 1).
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- startKey  in  1  start/fire key level, already synchronised.
- playerHit  in  1  one-cycle pulse: collision player/alien-shot.
- allAliensDead  in  1  one-cycle pulse: wave cleared.
- lives  out  MAX_LIVES  thermometer mask, bit0 = first life.
- startScreenEn  out  1  start bitmap enable.
- gameOverEn  out  1  game-over bitmap enable.
- gameRunning  out  1  high in PLAYING and HIT.
- playerVisible  out  1  player drawer enable.
- newGame  out  1  one-cycle pulse on game start.
- levelUp  out  1  one-cycle pulse on wave cleared.
- level  out  3  current level, 0-based.

Behaviour:
- All outputs are registered; an input event at cycle n is visible on the outputs at n+1.
- Reset values:
  - state=IDLE, lives=all ones, startScreenEn=1, gameOverEn=0, gameRunning=0, playerVisible=0, newGame=0, levelUp=0, level=0.
  - All counters cleared; keyPrev=0.
  - Reset in any state, mid-blink or mid-count, returns to exactly these values on the next edge.
- Key edge detection: keyPrev is a register; keyRise = startKey & ~keyPrev. A key held through reset produces no rise until it is released and pressed again.
- Frame counters advance only on startOfFrame. Internal frameCnt is 8 bits.
- States:
  - IDLE: startScreenEn=1. On keyRise -> PLAYING. Same edge: newGame=1, lives=all ones, level=0, playerVisible=1.
  - PLAYING: gameRunning=1, playerVisible=1.
    - playerHit with livesCnt>1: livesCnt-1, frameCnt=0, blinkCnt=0, playerVisible=0 -> HIT.
    - playerHit with livesCnt==1: livesCnt=0, lives=0 -> GAME_OVER, frameCnt=0.
    - allAliensDead (no hit in the same cycle): levelUp=1, level=min(level+1, MAX_LEVEL); stay in PLAYING.
    - Simultaneous playerHit and allAliensDead: the hit is processed; the clear is dropped.
  - HIT: gameRunning=1; playerHit is ignored (invulnerable).
    - allAliensDead is honoured as in PLAYING.
    - On each startOfFrame: frameCnt++ and blinkCnt++. When blinkCnt reaches BLINK_FRAMES-1, playerVisible toggles and blinkCnt=0.
    - When frameCnt reaches HIT_FRAMES-1 on a startOfFrame: -> PLAYING, playerVisible=1.
  - GAME_OVER: gameOverEn=1, gameRunning=0, playerVisible=0, lives=0; all inputs ignored.
    - When frameCnt reaches OVER_FRAMES-1 on a startOfFrame: -> IDLE, lives=all ones, startScreenEn=1.
- lives mask = (1<<livesCnt)-1, truncated to MAX_LIVES bits; it never wraps below 0.
- newGame and levelUp are high for exactly one cycle and are never asserted in the same cycle.
- startScreenEn and gameOverEn are mutually exclusive; both are 0 in PLAYING and HIT.

Test Plan:
- Reset, then a startKey rise -> next cycle: newGame=1 for 1 cycle, state PLAYING, lives=3'b111, startScreenEn=0, gameRunning=1, level=0.
- In PLAYING, pulse playerHit -> lives=3'b011, playerVisible=0. With BLINK_FRAMES=8, HIT_FRAMES=60: playerVisible toggles after frames 8,16,…,56, then returns to 1 with state PLAYING after frame 60. A second playerHit at frame 20 leaves lives=3'b011.
- Three hits, each separated by full HIT windows -> lives 111→011→001→000. On the third hit gameOverEn=1 and gameRunning=0. After 180 startOfFrame pulses: startScreenEn=1, lives=3'b111.
- Pulse allAliensDead 9 times in PLAYING -> levelUp pulses 9 times; level reaches 7 and saturates.
- playerHit and allAliensDead in the same cycle with lives=3 -> lives=3'b011, levelUp=0, level unchanged, state HIT.
- Assert resetN during HIT (frame 30) and during GAME_OVER -> next cycle all outputs equal reset values. startKey held high across reset -> no newGame until it is released and pressed again.
